// File: rtl/audio_pkg.sv
// Shared definitions for the I2S-style audio serializer: sample width, slot
// defaults, fetch FSM states and the slot bit-selection helper.
package audio_pkg;

    localparam int SAMPLE_W          = 18;
    localparam int SAMPLE_IDX_W      = $clog2(SAMPLE_W);
    localparam int DEFAULT_SLOT_BITS = 32;

    typedef enum logic [2:0] {
        FETCH_IDLE   = 3'd0,
        FETCH_CHECK  = 3'd1,
        FETCH_ACKH   = 3'd2,
        FETCH_ACKL   = 3'd3,
        FETCH_SETTLE = 3'd4
    } fetch_state_e;

    // Slot bit 0 is the I2S one-bit delay; bits 1..SAMPLE_W carry the sample MSB first.
    function automatic logic sample_bit(
        input logic [SAMPLE_W-1:0] sample,
        input logic [15:0]         slot_bit
    );
        logic [SAMPLE_IDX_W-1:0] idx;
        logic                    bit_v;
        idx = SAMPLE_IDX_W'(16'(SAMPLE_W) - slot_bit);
        if ((slot_bit >= 16'd1) && (slot_bit <= 16'(SAMPLE_W))) begin
            bit_v = sample[idx];
        end else begin
            bit_v = 1'b0;
        end
        return bit_v;
    endfunction

endpackage

// File: rtl/audio_bclk_gen.sv
// Bit-clock generator: divides clk by CLK_DIV per half-period and flags the
// cycle just before each bclk rising and falling edge.
module audio_bclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic bclk,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt_r;
    logic       bclk_r;
    logic       wrap_s;

    // terminal count of the half-period divider
    always_comb begin
        wrap_s = (div_cnt_r == DIV_LAST);
    end

    // half-period counter and bclk toggle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_r <= 8'd0;
            bclk_r    <= 1'b0;
        end else if (wrap_s) begin
            div_cnt_r <= 8'd0;
            bclk_r    <= ~bclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
        end
    end

    assign bclk = bclk_r;
    // Strobes are valid in the cycle whose closing edge moves bclk.
    assign rise = wrap_s & ~bclk_r;
    assign fall = wrap_s & bclk_r;

endmodule

// File: rtl/audio_serializer.sv
// Mono I2S serializer: emits one 18-bit sample in both slots of each frame and
// fetches the next sample from upstream with a two-cycle ack handshake.
module audio_serializer
    import audio_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int SLOT_BITS = DEFAULT_SLOT_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    input  logic [SAMPLE_W-1:0] dataIn,
    output logic                ack,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                underrun,
    output logic [7:0]          underrunCount
);

    localparam int               FRAME_BITS = 2 * SLOT_BITS;
    localparam int               CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_RIGHT  = CNT_W'(SLOT_BITS);

    logic                bclk_s;
    logic                bclk_rise_s;
    logic                bclk_fall_s;
    logic [CNT_W-1:0]    bit_cnt_r;
    logic [CNT_W-1:0]    bit_cnt_next_s;
    logic [CNT_W-1:0]    slot_bit_s;
    logic [SAMPLE_W-1:0] cur_sample_r;
    logic [SAMPLE_W-1:0] next_sample_r;
    logic                lrclk_r;
    logic                sdata_r;
    logic                ack_r;
    logic                underrun_r;
    logic [7:0]          underrun_cnt_r;
    logic [1:0]          settle_cnt_r;
    fetch_state_e        state_r;

    audio_bclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk_gen (
        .clk   (clk),
        .reset (reset),
        .bclk  (bclk_s),
        .rise  (bclk_rise_s),
        .fall  (bclk_fall_s)
    );

    // next bit count and its position within the current slot
    always_comb begin
        if (bit_cnt_r == CNT_LAST) begin
            bit_cnt_next_s = {CNT_W{1'b0}};
        end else begin
            bit_cnt_next_s = bit_cnt_r + CNT_W'(1);
        end
        if (bit_cnt_next_s >= CNT_RIGHT) begin
            slot_bit_s = bit_cnt_next_s - CNT_RIGHT;
        end else begin
            slot_bit_s = bit_cnt_next_s;
        end
    end

    // serial side: everything here moves only on bclk falling edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_r    <= {CNT_W{1'b0}};
            lrclk_r      <= 1'b0;
            sdata_r      <= 1'b0;
            cur_sample_r <= {SAMPLE_W{1'b0}};
        end else if (bclk_fall_s) begin
            bit_cnt_r <= bit_cnt_next_s;
            lrclk_r   <= (bit_cnt_next_s >= CNT_RIGHT);
            // slot bit 0 is always zero, so the old sample is safe at the wrap
            sdata_r   <= sample_bit(cur_sample_r, 16'(slot_bit_s));
            if (bit_cnt_next_s == {CNT_W{1'b0}}) begin
                cur_sample_r <= next_sample_r;
            end
        end
    end

    // fetch FSM; launched half a bclk into the right slot, well clear of the frame wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= FETCH_IDLE;
            ack_r          <= 1'b0;
            underrun_r     <= 1'b0;
            underrun_cnt_r <= 8'd0;
            next_sample_r  <= {SAMPLE_W{1'b0}};
            settle_cnt_r   <= 2'd0;
        end else begin
            underrun_r <= 1'b0;
            case (state_r)
                FETCH_IDLE: begin
                    if (bclk_rise_s && (bit_cnt_r == CNT_RIGHT)) begin
                        state_r <= FETCH_CHECK;
                    end
                end
                FETCH_CHECK: begin
                    if (valid) begin
                        next_sample_r <= dataIn;
                        ack_r         <= 1'b1;
                        state_r       <= FETCH_ACKH;
                    end else begin
                        underrun_r <= 1'b1;
                        if (underrun_cnt_r != 8'hFF) begin
                            underrun_cnt_r <= underrun_cnt_r + 8'd1;
                        end
                        state_r <= FETCH_IDLE;
                    end
                end
                FETCH_ACKH: begin
                    state_r <= FETCH_ACKL;
                end
                FETCH_ACKL: begin
                    ack_r        <= 1'b0;
                    settle_cnt_r <= 2'd0;
                    state_r      <= FETCH_SETTLE;
                end
                FETCH_SETTLE: begin
                    if (settle_cnt_r == 2'd2) begin
                        state_r <= FETCH_IDLE;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 2'd1;
                    end
                end
                default: begin
                    ack_r   <= 1'b0;
                    state_r <= FETCH_IDLE;
                end
            endcase
        end
    end

    assign ack           = ack_r;
    assign bclk          = bclk_s;
    assign lrclk         = lrclk_r;
    assign sdata         = sdata_r;
    assign underrun      = underrun_r;
    assign underrunCount = underrun_cnt_r;

endmodule

// File: tb/tb_audio_serializer.sv
// Self-checking bench: a frame-level reference model predicts bclk, lrclk,
// slot contents, ack and underrun behaviour from cycle arithmetic.
module tb_audio_serializer;

    localparam int CD         = 4;
    localparam int SB         = 32;
    localparam int BITP       = 2 * CD;
    localparam int SLOTP      = SB * BITP;
    localparam int FRAMEP     = 2 * SLOTP;
    localparam int MAXF       = 16;
    localparam int CD2        = 2;
    localparam int SB2        = 19;
    localparam int FRAMEP2    = 2 * SB2 * 2 * CD2;
    localparam int SAT_FRAMES = 270;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [17:0] dataIn = 18'd0;
    logic        ack, bclk, lrclk, sdata, underrun;
    logic [7:0]  underrunCount;

    logic        reset2 = 1'b1;
    logic        valid2 = 1'b0;
    logic [17:0] data2 = 18'd0;
    logic        ack2, bclk2, lrclk2, sdata2, underrun2;
    logic [7:0]  underrunCount2;

    always #5 clk = ~clk;

    audio_serializer #(.CLK_DIV(CD), .SLOT_BITS(SB)) dut (
        .clk(clk), .reset(reset), .valid(valid), .dataIn(dataIn),
        .ack(ack), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .underrun(underrun), .underrunCount(underrunCount)
    );

    audio_serializer #(.CLK_DIV(CD2), .SLOT_BITS(SB2)) dut_small (
        .clk(clk), .reset(reset2), .valid(valid2), .dataIn(data2),
        .ack(ack2), .bclk(bclk2), .lrclk(lrclk2), .sdata(sdata2),
        .underrun(underrun2), .underrunCount(underrunCount2)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int t;

    logic [31:0] obs_word [MAXF][2];
    int          ack_cyc [MAXF];
    int          ack_rise [MAXF];
    int          ack_first [MAXF];
    logic        ack_lr [MAXF];
    int          und_cyc [MAXF];
    int          glitch [MAXF];
    int          lr_toggles [MAXF];
    int          lr_gap_bad [MAXF];
    logic [7:0]  cnt_end [MAXF];
    logic        ack_prev, lr_prev;
    int          lr_last;

    logic [17:0] m_next;
    int          m_under;
    logic [17:0] m_air [MAXF];
    int          m_cnt [MAXF];

    function automatic logic [31:0] slot_word(input logic [17:0] smp);
        logic [31:0] w;
        w = 32'd0;
        for (int b = 1; b <= 18; b++) w[b] = smp[18-b];
        return w;
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        t = 0;
        m_next = 18'd0;
        m_under = 0;
        ack_prev = 1'b0;
        lr_prev = 1'b0;
        lr_last = -1;
    endtask

    // Drive one frame of inputs, record what the DUT emits, then advance the model.
    task automatic run_frame(input logic v, input logic [17:0] d);
        int f, c, s, b;
        f = t / FRAMEP;
        if (f >= MAXF) begin
            $display("FAIL frame_index actual=%0d required<%0d", f, MAXF);
            $fatal(1, "frame record overflow");
        end
        valid = v;
        dataIn = d;
        m_air[f] = m_next;
        obs_word[f][0] = 32'd0;
        obs_word[f][1] = 32'd0;
        ack_cyc[f] = 0; ack_rise[f] = 0; ack_first[f] = -1; ack_lr[f] = 1'b0;
        und_cyc[f] = 0; glitch[f] = 0; lr_toggles[f] = 0; lr_gap_bad[f] = 0;
        for (int k = 0; k < FRAMEP; k++) begin
            c = (t / BITP) % (2 * SB);
            s = c / SB;
            b = c % SB;
            if (bclk !== 1'((t / CD) % 2) || lrclk !== (c >= SB)) glitch[f]++;
            if (t % BITP == 0) obs_word[f][s][b] = sdata;
            else if (sdata !== obs_word[f][s][b]) glitch[f]++;
            if (lrclk !== lr_prev) begin
                lr_toggles[f]++;
                if (lr_last >= 0 && (t - lr_last) != SLOTP) lr_gap_bad[f]++;
                lr_last = t;
            end
            lr_prev = lrclk;
            if (ack === 1'b1) begin
                if (ack_prev !== 1'b1) begin
                    ack_rise[f]++;
                    if (ack_first[f] < 0) begin
                        ack_first[f] = t;
                        ack_lr[f] = lrclk;
                    end
                end
                ack_cyc[f]++;
            end
            ack_prev = ack;
            if (underrun === 1'b1) und_cyc[f]++;
            cnt_end[f] = underrunCount;
            @(posedge clk);
            #1;
            t++;
        end
        if (v) m_next = d;
        else if (m_under < 255) m_under++;
        m_cnt[f] = m_under;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        valid = 1'b1;
        dataIn = 18'($urandom);
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if ({ack, bclk, lrclk, sdata, underrun} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs actual=%b required=00000", {ack, bclk, lrclk, sdata, underrun});
        end
        tests_run++;
        if (underrunCount !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_count actual=%0d required=0", underrunCount);
        end
    endtask

    task automatic test_fixed_sample();
        logic [31:0] exp;
        apply_reset();
        for (int f = 0; f < 3; f++) run_frame(1'b1, 18'h2ABCD);
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < 2; s++) begin
                exp = slot_word(m_air[f]);
                tests_run++;
                if (obs_word[f][s] !== exp) begin
                    tests_failed++;
                    $display("FAIL fixed_slot f=%0d s=%0d actual=%h required=%h", f, s, obs_word[f][s], exp);
                end
            end
        end
        tests_run++;
        if (glitch[0] + glitch[1] + glitch[2] != 0) begin
            tests_failed++;
            $display("FAIL fixed_timing actual=%0d required=0", glitch[0] + glitch[1] + glitch[2]);
        end
    endtask

    task automatic test_ack_handshake();
        apply_reset();
        for (int f = 0; f < 4; f++) run_frame(1'b1, 18'($urandom));
        for (int f = 0; f < 4; f++) begin
            tests_run++;
            if (ack_cyc[f] != 2 || ack_rise[f] != 1 || ack_lr[f] !== 1'b1 || und_cyc[f] != 0) begin
                tests_failed++;
                $display("FAIL ack_pulse f=%0d actual=cyc%0d/rise%0d/lr%b/und%0d required=cyc2/rise1/lr1/und0",
                         f, ack_cyc[f], ack_rise[f], ack_lr[f], und_cyc[f]);
            end
            if (f > 0) begin
                tests_run++;
                if (ack_first[f] - ack_first[f-1] != FRAMEP) begin
                    tests_failed++;
                    $display("FAIL ack_period f=%0d actual=%0d required=%0d", f, ack_first[f] - ack_first[f-1], FRAMEP);
                end
            end
        end
    endtask

    task automatic test_random_stream();
        logic        v;
        logic [31:0] exp;
        logic        vs [10];
        apply_reset();
        for (int f = 0; f < 10; f++) begin
            v = (f == 3) ? 1'b0 : ($urandom_range(0, 3) != 0);
            vs[f] = v;
            run_frame(v, 18'($urandom));
        end
        for (int f = 0; f < 10; f++) begin
            exp = slot_word(m_air[f]);
            tests_run++;
            if (obs_word[f][0] !== exp || obs_word[f][1] !== exp || glitch[f] != 0) begin
                tests_failed++;
                $display("FAIL rand_slots f=%0d actual=%h/%h glitch%0d required=%h/%h glitch0",
                         f, obs_word[f][0], obs_word[f][1], glitch[f], exp, exp);
            end
            tests_run++;
            if (und_cyc[f] != (vs[f] ? 0 : 1) || ack_cyc[f] != (vs[f] ? 2 : 0)) begin
                tests_failed++;
                $display("FAIL rand_fetch f=%0d actual=und%0d/ack%0d required=und%0d/ack%0d",
                         f, und_cyc[f], ack_cyc[f], vs[f] ? 0 : 1, vs[f] ? 2 : 0);
            end
            tests_run++;
            if (cnt_end[f] !== 8'(m_cnt[f])) begin
                tests_failed++;
                $display("FAIL rand_count f=%0d actual=%0d required=%0d", f, cnt_end[f], m_cnt[f]);
            end
        end
    endtask

    task automatic test_underrun();
        logic [17:0] d1;
        d1 = 18'($urandom);
        apply_reset();
        run_frame(1'b1, d1);
        run_frame(1'b0, ~d1);
        run_frame(1'b1, 18'($urandom));
        tests_run++;
        if (und_cyc[0] != 0 || und_cyc[1] != 1 || ack_cyc[1] != 0) begin
            tests_failed++;
            $display("FAIL underrun_pulse actual=%0d/%0d ack%0d required=0/1 ack0", und_cyc[0], und_cyc[1], ack_cyc[1]);
        end
        tests_run++;
        if (cnt_end[1] !== 8'd1) begin
            tests_failed++;
            $display("FAIL underrun_count actual=%0d required=1", cnt_end[1]);
        end
        tests_run++;
        if (obs_word[2][0] !== slot_word(d1) || obs_word[2][1] !== slot_word(d1)) begin
            tests_failed++;
            $display("FAIL underrun_repeat actual=%h/%h required=%h", obs_word[2][0], obs_word[2][1], slot_word(d1));
        end
    endtask

    task automatic test_all_ones();
        apply_reset();
        run_frame(1'b1, 18'h3FFFF);
        run_frame(1'b1, 18'h3FFFF);
        tests_run++;
        if (obs_word[1][0] !== 32'h0007_FFFE || obs_word[1][1] !== 32'h0007_FFFE) begin
            tests_failed++;
            $display("FAIL ones_slots actual=%h/%h required=0007fffe", obs_word[1][0], obs_word[1][1]);
        end
        tests_run++;
        if (lr_toggles[1] != 2 || lr_gap_bad[0] + lr_gap_bad[1] != 0) begin
            tests_failed++;
            $display("FAIL lrclk_period actual=toggles%0d/bad%0d required=toggles2/bad0",
                     lr_toggles[1], lr_gap_bad[0] + lr_gap_bad[1]);
        end
    endtask

    task automatic test_reset_mid_fetch();
        logic seen;
        apply_reset();
        valid = 1'b1;
        dataIn = 18'($urandom) | 18'h00001;
        seen = 1'b0;
        for (int k = 0; k < FRAMEP && !seen; k++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL ack_seen actual=0 required=1 within %0d cycles", FRAMEP);
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({ack, bclk, lrclk, sdata, underrun} !== 5'b0 || underrunCount !== 8'd0) begin
            tests_failed++;
            $display("FAIL async_reset actual=%b cnt%0d required=00000 cnt0", {ack, bclk, lrclk, sdata, underrun}, underrunCount);
        end
        repeat (4) @(posedge clk);
        #1;
        tests_run++;
        if ({ack, bclk, lrclk, sdata, underrun} !== 5'b0 || underrunCount !== 8'd0) begin
            tests_failed++;
            $display("FAIL held_reset actual=%b cnt%0d required=00000 cnt0", {ack, bclk, lrclk, sdata, underrun}, underrunCount);
        end
        apply_reset();
        run_frame(1'b0, 18'($urandom));
        run_frame(1'b0, 18'($urandom));
        tests_run++;
        if (obs_word[1][0] !== 32'd0 || obs_word[1][1] !== 32'd0 || cnt_end[1] !== 8'd2) begin
            tests_failed++;
            $display("FAIL discard_sample actual=%h/%h cnt%0d required=0/0 cnt2", obs_word[1][0], obs_word[1][1], cnt_end[1]);
        end
    endtask

    task automatic test_saturation();
        int         pulses, wraps, ack_hi;
        logic [7:0] prev;
        reset2 = 1'b1;
        valid2 = 1'b0;
        data2 = 18'($urandom);
        repeat (3) @(posedge clk);
        #1;
        reset2 = 1'b0;
        pulses = 0; wraps = 0; ack_hi = 0; prev = 8'd0;
        for (int k = 1; k <= SAT_FRAMES * FRAMEP2; k++) begin
            @(posedge clk);
            #1;
            if (underrun2 === 1'b1) pulses++;
            if (underrunCount2 < prev) wraps++;
            prev = underrunCount2;
            if (ack2 === 1'b1) ack_hi++;
            if (k == 100 * FRAMEP2) begin
                tests_run++;
                if (underrunCount2 !== 8'd100) begin
                    tests_failed++;
                    $display("FAIL sat_midway actual=%0d required=100", underrunCount2);
                end
            end
        end
        tests_run++;
        if (underrunCount2 !== 8'd255 || wraps != 0) begin
            tests_failed++;
            $display("FAIL sat_count actual=%0d wraps%0d required=255 wraps0", underrunCount2, wraps);
        end
        tests_run++;
        if (pulses != SAT_FRAMES || ack_hi != 0) begin
            tests_failed++;
            $display("FAIL sat_pulses actual=%0d ack%0d required=%0d ack0", pulses, ack_hi, SAT_FRAMES);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_sample();
        test_ack_handshake();
        test_random_stream();
        test_underrun();
        test_all_ones();
        test_reset_mid_fetch();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
